// File: rtl/bcd_7seg_scan.sv
// Two-digit common-anode 7-segment display driver for a latched BCD word {tens, units}.
// One refresh counter alternates the units and tens digits; seg/an are registered so they never glitch.
module bcd_7seg_scan #(
  parameter int unsigned REFRESH_DIV        = 50000,
  parameter bit          SEG_ACTIVE_LOW     = 1'b1,
  parameter bit          BLANK_LEADING_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [4:0] bcd_in,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [4:0] value,
  output logic       err
);

  localparam int unsigned    CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]     DASH = 7'b0000001;
  localparam logic [6:0]     DARK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic {UNITS, TENS} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] refreshCnt_q, refreshCnt_d;
  logic [4:0]       value_q;
  logic             err_q;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;
  logic [6:0]       pattern;
  logic             wrap;

  function automatic logic [6:0] digitPattern(input logic [3:0] digit);
    unique case (digit)
      4'd0:    digitPattern = 7'b1111110;
      4'd1:    digitPattern = 7'b0110000;
      4'd2:    digitPattern = 7'b1101101;
      4'd3:    digitPattern = 7'b1111001;
      4'd4:    digitPattern = 7'b0110011;
      4'd5:    digitPattern = 7'b1011011;
      4'd6:    digitPattern = 7'b1011111;
      4'd7:    digitPattern = 7'b1110000;
      4'd8:    digitPattern = 7'b1111111;
      4'd9:    digitPattern = 7'b1111011;
      default: digitPattern = DASH;
    endcase
  endfunction

  // Capture the BCD word; the legality flag is frozen together with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= 5'd0;
      err_q   <= 1'b0;
    end else if (load) begin
      value_q <= bcd_in;
      err_q   <= (bcd_in[3:0] > 4'd9);
    end
  end

  // State register: scan slot and its refresh counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= UNITS;
      refreshCnt_q <= '0;
    end else begin
      state_q      <= state_d;
      refreshCnt_q <= refreshCnt_d;
    end
  end

  always_comb begin
    wrap         = (refreshCnt_q == LAST);
    refreshCnt_d = wrap ? '0 : refreshCnt_q + 1'b1;
    state_d      = state_q;
    if (wrap) state_d = (state_q == UNITS) ? TENS : UNITS;
  end

  // Pin values for the current slot; they land on the pins one edge later.
  always_comb begin
    pattern = 7'b0000000;
    an_d    = 2'b11;
    unique case (state_q)
      UNITS: begin
        an_d    = 2'b10;
        pattern = err_q ? DASH : digitPattern(value_q[3:0]);
      end
      TENS: begin
        if (err_q) begin
          an_d    = 2'b01;
          pattern = DASH;
        end else if (!value_q[4] && BLANK_LEADING_ZERO) begin
          an_d    = 2'b11;
          pattern = 7'b0000000;
        end else begin
          an_d    = 2'b01;
          pattern = digitPattern({3'b000, value_q[4]});
        end
      end
      default: begin
        an_d    = 2'b11;
        pattern = 7'b0000000;
      end
    endcase
    seg_d = SEG_ACTIVE_LOW ? ~pattern : pattern;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= DARK;
      an_q  <= 2'b11;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign value = value_q;
  assign err   = err_q;

endmodule
